uart_rx_frame_ctrl: RTL
=======================

Name: uart_rx_frame_ctrl

Overview:
- Receive-side sequencer for the UART RX path.
- Oversamples the serial line, detects and qualifies the start bit, and deserializes 8 data bits LSB-first, plus an optional parity bit and the stop bit.
- Presents the frame fields, with a one-cycle recieved_flag strobe, to the existing ErrorCheck block.
- Captures ErrorCheck's 3-bit error_flag and delivers data_out, data_valid and error_out to the consumer.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit period; must be even and ≥ 4.
- DATA_WIDTH, 8, data bits per frame; fixed at 8 for ErrorCheck compatibility.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- baud_tick  input  1  one-cycle oversample strobe at OVERSAMPLE × baud rate.
- rx_in  input  1  raw serial line; idle high; asynchronous to clock.
- parity_type  input  2  00 none, 01 odd, 10 even, 11 none; sampled at start qualification.
- start_bit  output  1  sampled start bit value, to ErrorCheck.
- raw_data  output  8  deserialized data, to ErrorCheck.
- parity_bit  output  1  sampled parity bit (0 when parity is none), to ErrorCheck.
- stop_bit  output  1  sampled stop bit, to ErrorCheck.
- parity_type_o  output  2  latched parity_type for the frame, to ErrorCheck.
- recieved_flag  output  1  one-cycle strobe: frame fields are valid.
- error_flag  input  3  from ErrorCheck; bit0 parity error, bit1 start error, bit2 stop error.
- data_out  output  8  last received byte.
- data_valid  output  1  one-cycle strobe: data_out and error_out updated.
- error_out  output  3  error_flag captured for the frame in data_out.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: every output is 0, except stop_bit = 1 and start_bit = 1 (idle line levels). FSM goes to IDLE; counters, synchronizer and shift register clear to their idle values (synchronizer flops = 1).
- rx_in passes through a 2-flop synchronizer (rx_s). Every "sample" below means rx_s, taken on a baud_tick. All latency figures include the 2 synchronizer cycles.
- tick_cnt counts baud_tick pulses from 0 to OVERSAMPLE-1 and wraps. bit_cnt has 3 bits.
- IDLE:
  - rx_s = 0 seen on a baud_tick → START, with tick_cnt = 0.
  - Otherwise stay in IDLE.
- START:
  - When tick_cnt reaches OVERSAMPLE/2 - 1 (mid-bit), sample the line.
  - Sample 0 → latch start_bit = 0 and parity_type → parity_type_o; reset tick_cnt; bit_cnt = 0; go to DATA.
  - Sample 1 → false start; return to IDLE. No strobe; outputs unchanged.
- DATA:
  - Every OVERSAMPLE ticks, shift the sample into raw_data[bit_cnt] (LSB first).
  - After bit 7: if parity_type_o ∈ {01, 10} go to PARITY, else set parity_bit = 0 and go to STOP.
- PARITY: after OVERSAMPLE ticks, latch the sample into parity_bit; go to STOP.
- STOP: after OVERSAMPLE ticks, latch the sample into stop_bit; go to CHECK.
  - A low stop bit does not abort the frame; ErrorCheck reports it.
- CHECK (exactly one clock):
  - recieved_flag = 1 for this cycle.
  - ErrorCheck is combinational; error_flag is valid in the same cycle.
- DELIVER (exactly one clock):
  - On entry, data_out ← raw_data and error_out ← registered error_flag; data_valid = 1 for this one cycle.
  - Then → IDLE.
  - If stop_bit = 0 (break or framing error), go to IDLE only after rx_s = 1. This prevents re-triggering on a held-low line.
- baud_tick is ignored while in CHECK and DELIVER.
- A new start edge is accepted from the first baud_tick in IDLE, so back-to-back frames need no idle gap beyond the stop bit.
- raw_data, start_bit, parity_bit and stop_bit hold between frames. The consumer needs no handshake: it must accept data_valid when it is asserted, and there is no backpressure.
- reset_n asserted mid-frame aborts immediately to reset values; no partial strobe.
- A parity_type change mid-frame has no effect until the next start qualification.

Decomposition:
- Shared package uart_pkg holds:
  - parity encodings PAR_NONE=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10;
  - error bit indices ERR_PARITY=0, ERR_START=1, ERR_STOP=2;
  - the FSM state enumeration;
  - the OVERSAMPLE default.
- One natural sub-module: uart_rx_sync, the 2-flop synchronizer with reset value 1.
- The FSM, counters and shift register stay in the top module.

Test Plan:
- Reset hold: reset_n = 0 for 3 cycles with rx_in toggling → all outputs at reset values, busy = 0, no strobes.
- Clean frame, parity none: send 0xA5 (00) with stop = 1 → exactly one recieved_flag, raw_data = 8'hA5, then data_valid with data_out = 8'hA5, error_out = 3'b000.
- Odd parity error: parity_type = 01, send 0x03 with parity bit 0 (correct is 1) → ErrorCheck returns 001; error_out = 3'b001, data_out = 8'h03.
- Framing error / break: send 0x00 with stop = 0, then hold rx_in low for 40 bit times → one data_valid with error_out bit2 = 1. No further frames until rx_in returns high, then a next frame 0x5A decodes correctly.
- False start: pulse rx_in low for 4 baud_ticks (< OVERSAMPLE/2) → FSM returns to IDLE; no recieved_flag or data_valid; busy high for fewer than 8 ticks.
- Reset mid-frame then back-to-back: assert reset_n during DATA bit 4 → clean abort. Then send 0x11 and 0xEE (even parity) with no idle gap → two data_valid pulses, data_out 8'h11 then 8'hEE, error_out = 0 for both.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART RX definitions: parity encodings, error bit
// indices, receive FSM states and the default oversample ratio.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int ERR_PARITY = 0;
  localparam int ERR_START  = 1;
  localparam int ERR_STOP   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_CHECK,
    ST_DELIVER,
    ST_BREAK
  } rx_state_e;

  function automatic logic par_en(input logic [1:0] t);
    return (t == PAR_ODD) || (t == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw serial line; resets to the
// idle (high) level. Ports: clock, reset_n, d_i (async), q_o.
module uart_rx_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ff_q <= 2'b11;
    else          ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame sequencer: start qualification, LSB-first data,
// optional parity, stop, ErrorCheck hand-off and byte delivery.
// Ports: clock/reset_n, baud_tick, rx_in, parity_type in;
// frame fields + recieved_flag to ErrorCheck, error_flag back;
// data_out/data_valid/error_out to consumer; busy status.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  baud_tick,
  input  logic                  rx_in,
  input  logic [1:0]            parity_type,
  output logic                  start_bit,
  output logic [DATA_WIDTH-1:0] raw_data,
  output logic                  parity_bit,
  output logic                  stop_bit,
  output logic [1:0]            parity_type_o,
  output logic                  recieved_flag,
  input  logic [2:0]            error_flag,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [2:0]            error_out,
  output logic                  busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_WIDTH - 1);

  logic rx_s;

  rx_state_e state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_WIDTH-1:0] raw_q, raw_d;
  logic start_q, start_d;
  logic par_q, par_d;
  logic stop_q, stop_d;
  logic [1:0] ptype_q, ptype_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic dv_q, dv_d;
  logic [2:0] err_q, err_d;

  uart_rx_sync u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d_i     (rx_in),
    .q_o     (rx_s)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      raw_q   <= '0;
      start_q <= 1'b1;
      par_q   <= 1'b0;
      stop_q  <= 1'b1;
      ptype_q <= PAR_NONE;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      raw_q   <= raw_d;
      start_q <= start_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      ptype_q <= ptype_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    raw_d   = raw_q;
    start_d = start_q;
    par_d   = par_q;
    stop_d  = stop_q;
    ptype_d = ptype_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (baud_tick && !rx_s) begin
          state_d = ST_START;
          tick_d  = '0;
        end
      end

      ST_START: begin
        if (baud_tick) begin
          if (tick_q == HALF) begin
            if (!rx_s) begin
              start_d = 1'b0;
              ptype_d = parity_type;
              tick_d  = '0;
              bit_d   = '0;
              state_d = ST_DATA;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (baud_tick) begin
          if (tick_q == LAST) begin
            tick_d       = '0;
            raw_d[bit_q] = rx_s;
            bit_d        = bit_q + 3'd1;
            if (bit_q == BIT_LAST) begin
              if (par_en(ptype_q)) begin
                state_d = ST_PARITY;
              end else begin
                par_d   = 1'b0;
                state_d = ST_STOP;
              end
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (baud_tick) begin
          if (tick_q == LAST) begin
            tick_d  = '0;
            par_d   = rx_s;
            state_d = ST_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (baud_tick) begin
          if (tick_q == LAST) begin
            tick_d  = '0;
            stop_d  = rx_s;
            state_d = ST_CHECK;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      // ErrorCheck is combinational on the presented fields,
      // so its verdict is captured alongside the byte here.
      ST_CHECK: begin
        dout_d  = raw_q;
        err_d   = error_flag;
        dv_d    = 1'b1;
        state_d = ST_DELIVER;
      end

      // A low stop bit may be a break: hold off re-arming
      // until the line has gone back high.
      ST_DELIVER: begin
        if (stop_q || rx_s) state_d = ST_IDLE;
        else                state_d = ST_BREAK;
      end

      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign start_bit     = start_q;
  assign raw_data      = raw_q;
  assign parity_bit    = par_q;
  assign stop_bit      = stop_q;
  assign parity_type_o = ptype_q;
  assign recieved_flag = (state_q == ST_CHECK);
  assign data_out      = dout_q;
  assign data_valid    = dv_q;
  assign error_out     = err_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
